// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 bit-select mux.
// Grants are registered and stay with the owner while it keeps requesting,
// up to MAX_HOLD consecutive cycles. After that the grant rotates fairly.
//
// state | meaning
// IDLE  | no owner, grant=0, waiting for any request
// GRANT | sel owns the mux; hold_cnt counts cycles owned minus one
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        gnt_valid,
  output logic [3:0]  ptr
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;

  // First set bit of r scanning upward from s, wrapping 15 -> 0.
  // Scanning the offsets from high to low lets the closest hit win.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] s);
    logic [3:0] idx;
    logic [3:0] w;
    w = s;
    for (int k = 15; k >= 0; k--) begin
      idx = s + 4'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  logic [3:0] win_idle;
  logic [3:0] win_next;
  logic       keep_owner;

  // Candidate winners: from ptr when idle, from owner+1 when leaving GRANT
  // (the owner is then scanned last, which makes a solo owner re-win).
  always_comb begin
    win_idle   = rr_pick(req, ptr);
    win_next   = rr_pick(req, sel + 4'd1);
    keep_owner = req[sel] && (hold_cnt < HOLD_W'(MAX_HOLD - 1));
  end

  // Arbitration FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            grant     <= 16'd1 << win_idle;
            sel       <= win_idle;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            ptr       <= win_idle + 4'd1;
          end
        end
        GRANT: begin
          if (keep_owner) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (req == 16'd0) begin
            // sel and ptr intentionally keep their last values
            state     <= IDLE;
            grant     <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end else begin
            // release with others waiting, or hold cap reached
            grant     <= 16'd1 << win_next;
            sel       <= win_next;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            ptr       <= win_next + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter. Three instances cover MAX_HOLD of
// 8, 2 and 1. The stimulus pushes a hand-computed expectation for each cycle,
// and the monitor pops it and compares it one edge later.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req8, req2, req1;
  logic [15:0] grant8, grant2, grant1;
  logic [3:0]  sel8, sel2, sel1;
  logic [3:0]  ptr8, ptr2, ptr1;
  logic        valid8, valid2, valid1;

  mux16_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .grant(grant8),
    .sel(sel8), .gnt_valid(valid8), .ptr(ptr8));

  mux16_rr_arbiter #(.MAX_HOLD(2), .HOLD_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .grant(grant2),
    .sel(sel2), .gnt_valid(valid2), .ptr(ptr2));

  mux16_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .grant(grant1),
    .sel(sel1), .gnt_valid(valid1), .ptr(ptr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic [3:0]  ptr;
    logic        valid;
    logic        fair;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   fcnt [16];

  // Drive req on the falling edge and queue what must appear after the next rising edge.
  task automatic step(input int dut, input logic [15:0] r, input logic [15:0] g,
                      input logic [3:0] s, input logic [3:0] p, input string tag,
                      input logic fair = 1'b0);
    exp_t e;
    @(negedge clk);
    case (dut)
      0: req8 = r;
      1: req2 = r;
      default: req1 = r;
    endcase
    e.dut = dut; e.grant = g; e.sel = s; e.ptr = p;
    e.valid = (g != 16'd0); e.fair = fair; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, checked just after the rising edge.
  always @(posedge clk) begin
    exp_t        e;
    logic [15:0] ag;
    logic [3:0]  as, ap;
    logic        av;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.dut)
        0:       begin ag = grant8; as = sel8; ap = ptr8; av = valid8; end
        1:       begin ag = grant2; as = sel2; ap = ptr2; av = valid2; end
        default: begin ag = grant1; as = sel1; ap = ptr1; av = valid1; end
      endcase
      nvec++;
      if (ag !== e.grant || as !== e.sel || ap !== e.ptr || av !== e.valid) begin
        nerr++;
        $display("FAIL %s dut%0d: got grant=%h sel=%0d ptr=%0d valid=%b, want grant=%h sel=%0d ptr=%0d valid=%b",
                 e.tag, e.dut, ag, as, ap, av, e.grant, e.sel, e.ptr, e.valid);
      end
      if (e.fair) begin
        for (int i = 0; i < 16; i++) if (ag[i]) fcnt[i]++;
      end
    end
  end

  task automatic check_reset(input string tag);
    nvec++;
    if (grant8 !== 16'd0 || sel8 !== 4'd0 || valid8 !== 1'b0 || ptr8 !== 4'd0) begin
      nerr++;
      $display("FAIL %s: got grant=%h sel=%0d ptr=%0d valid=%b, want all zero",
               tag, grant8, sel8, ptr8, valid8);
    end
  endtask

  initial begin
    int drain;
    for (int i = 0; i < 16; i++) fcnt[i] = 0;
    rst_n = 1'b0;
    req8 = '0; req2 = '0; req1 = '0;
    repeat (2) @(negedge clk);
    check_reset("reset_init");
    rst_n = 1'b1;

    // MAX_HOLD=8: single requester, back-to-back release, solo expiry
    step(0, 16'h0000, 16'h0000, 4'd0, 4'd0, "idle");
    step(0, 16'h0010, 16'h0010, 4'd4, 4'd5, "single");
    step(0, 16'h0000, 16'h0000, 4'd4, 4'd5, "single_drop");
    step(0, 16'h0008, 16'h0008, 4'd3, 4'd4, "own3");
    step(0, 16'h0108, 16'h0008, 4'd3, 4'd4, "own3_hold");
    step(0, 16'h0100, 16'h0100, 4'd8, 4'd9, "b2b_release");
    step(0, 16'h0000, 16'h0000, 4'd8, 4'd9, "idle_after_b2b");
    for (int k = 0; k < 20; k++)
      step(0, 16'h0004, 16'h0004, 4'd2, 4'd3, "solo_expiry");
    step(0, 16'h0000, 16'h0000, 4'd2, 4'd3, "idle_after_solo");
    step(0, 16'h0020, 16'h0020, 4'd5, 4'd6, "own5");

    // async reset in the middle of owner 5's grant, checked before the next edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_grant");
    @(negedge clk);
    req8 = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // MAX_HOLD=2: two requesters straddling the wrap, sel 0,0,15,15,...
    for (int k = 0; k < 8; k++) begin
      if (((k / 2) % 2) == 0)
        step(1, 16'h8001, 16'h0001, 4'd0, 4'd1, "rr_wrap");
      else
        step(1, 16'h8001, 16'h8000, 4'd15, 4'd0, "rr_wrap");
    end
    step(1, 16'h0000, 16'h0000, 4'd15, 4'd0, "rr_idle");

    // MAX_HOLD=1: all requesting, one cycle each in index order
    for (int k = 0; k < 32; k++)
      step(2, 16'hFFFF, 16'd1 << (k % 16), 4'(k % 16), 4'((k + 1) % 16), "fair_sweep", 1'b1);
    step(2, 16'h0000, 16'h0000, 4'd15, 4'd0, "fair_idle");

    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (q.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (fcnt[i] != 2) begin
        nerr++;
        $display("FAIL fair_count[%0d]: got %0d grants, want 2", i, fcnt[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
